full_adder_checker: RTL and testbench
=====================================

# full_adder_checker

Hardware self-checking sequencer for the lab full adder. On `start` it drives all eight `{ci, xi, yi}` input combinations into a combinational full adder in ascending order. It holds each vector for a fixed number of clocks and samples the adder's `cout`/`si` at the end of each hold, comparing them against the expected sum and carry. It reports busy/done, a saturating error count, the first failing vector and an overall pass flag. It replaces manual waveform inspection on the board.

## Interface
- `HOLD_CYCLES`, default 4: clocks each vector is held; legal range ≥ 2.
- `ERR_W`, default 4: width of the error counter.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: run request, sampled on the rising edge of `clk`.
- `ci_o`, `xi_o`, `yi_o`  out  1 each: stimulus to the adder under test; registered.
- `cout_i`, `si_i`  in  1 each: adder under test outputs (combinational from `ci_o`/`xi_o`/`yi_o`).
- `busy`  out  1: high while vectors are being applied.
- `done`  out  1: high from run completion until the next accepted start or reset.
- `pass`  out  1: equals `done && err_count == 0`.
- `err_count`  out  `ERR_W`: number of mismatching vectors, saturating at 2^`ERR_W`−1.
- `first_fail_valid`  out  1: at least one mismatch recorded this run.
- `first_fail_vec`  out  3: `{ci, xi, yi}` of the first mismatching vector.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - DONE.
- Internal registers:
  - `vec[2:0]`: current vector.
  - `hold`: counts 0..`HOLD_CYCLES`−1.
- Stimulus mapping: `{ci_o, xi_o, yi_o} = vec` while in RUN; all three outputs are 0 in IDLE and DONE.
- Expected values:
  - sum = `ci ^ xi ^ yi`.
  - carry = `(ci&xi) | (ci&yi) | (xi&yi)`.
  - A mismatch is any difference on `si_i` or on `cout_i`. Each vector counts at most 1 error.
- IDLE → RUN on `start`=1. Clears `err_count`, `first_fail_valid` and `first_fail_vec`; sets `vec`=0 and `hold`=0.
- RUN:
  - `hold` increments each clock.
  - At the clock where `hold`==`HOLD_CYCLES`−1, the adder outputs are compared. On a mismatch, `err_count` increments (saturating). If `first_fail_valid` is 0, `first_fail_vec` is set to `vec` and `first_fail_valid` to 1.
  - On that same edge `hold` returns to 0 and `vec` increments. If `vec` was 7, the state goes to DONE instead.
- DONE → RUN on `start`=1, with the same clearing as IDLE → RUN. Results stay stable until then.
- `start` is ignored in RUN.
- Reset (asynchronous, including mid-run): state IDLE, `vec`=0, `hold`=0, every output 0.

## Timing
- A start accepted at edge E0 gives `busy`=1 and vector 0 on the outputs after E0.
- Each vector is driven for exactly `HOLD_CYCLES` clocks. The adder gets `HOLD_CYCLES`−1 clocks to settle before sampling.
- `busy` stays high for exactly 8×`HOLD_CYCLES` clocks.
- `done`, `pass`, `err_count` and `first_fail_*` are valid on the same edge that drops `busy`. No cycle exists with both `busy` and `done` high.
- The compare result for the last vector (7) is included in the final `err_count` visible with `done`.
- `err_count` updates one edge after each compare point and is monotonic within a run.
- Saturation: once `err_count` reaches all ones, further mismatches leave it unchanged. `first_fail_*` is unaffected by saturation.
- Asynchronous reset takes effect immediately, without waiting for a clock edge. The first start after reset deasserts is accepted normally.

## Test plan
- **Correct adder model, `HOLD_CYCLES`=4, 1-cycle start pulse:** `busy` high for 32 clocks; stimulus steps 000→111 every 4 clocks; at the end `done`=1, `pass`=1, `err_count`=0, `first_fail_valid`=0.
- **Faulty DUT, `si` stuck at 0:** mismatches on vectors 1, 2, 4, 7. Expect `err_count`=4, `first_fail_vec`=001, `first_fail_valid`=1, `pass`=0.
- **Faulty DUT with `cout` and `si` swapped:** vectors 0 and 7 pass. Expect `err_count`=6, `first_fail_vec`=001.
- **`ERR_W`=2 with `si` inverted:** 8 mismatches. Expect `err_count` saturates at 3 and `first_fail_vec`=000.
- **Reset, start-while-busy and restart:** assert `rst` at clock 10 of a run; all outputs go 0 immediately. A fresh start then completes with `pass`=1. A `start` pulse while `busy` is ignored: the run length is still 32 clocks. A `start` in DONE clears previous results and reruns.

Source files
------------

// File: rtl/full_adder_checker.sv
// Self-checking sequencer for the lab full adder. It walks all eight {ci, xi, yi}
// vectors, samples the adder at the end of each hold window and reports the results.
module full_adder_checker #(
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ci_o,
    output logic             xi_o,
    output logic             yi_o,
    input  logic             cout_i,
    input  logic             si_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [2:0]       first_fail_vec
);

    localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic fa_sum(input logic [2:0] v);
        return v[2] ^ v[1] ^ v[0];
    endfunction

    function automatic logic fa_carry(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    state_t            state_r, state_s;
    logic [2:0]        vec_r, vec_s;
    logic [HOLD_W-1:0] hold_r, hold_s;
    logic [ERR_W-1:0]  err_r, err_s;
    logic              ffv_r, ffv_s;
    logic [2:0]        ffvec_r, ffvec_s;
    logic              mismatch_s;

    assign err_count        = err_r;
    assign first_fail_valid = ffv_r;
    assign first_fail_vec   = ffvec_r;

    // Next-state, vector stepping and result accumulation
    always_comb begin
        state_s    = state_r;
        vec_s      = vec_r;
        hold_s     = hold_r;
        err_s      = err_r;
        ffv_s      = ffv_r;
        ffvec_s    = ffvec_r;
        mismatch_s = (si_i != fa_sum(vec_r)) || (cout_i != fa_carry(vec_r));
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_RUN;
                    vec_s   = 3'd0;
                    hold_s  = '0;
                    err_s   = '0;
                    ffv_s   = 1'b0;
                    ffvec_s = 3'd0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (hold_r == HOLD_LAST) begin
                    hold_s = '0;
                    if (mismatch_s) begin
                        err_s = (err_r == ERR_MAX) ? err_r : err_r + {{(ERR_W-1){1'b0}}, 1'b1};
                        if (!ffv_r) begin
                            ffv_s   = 1'b1;
                            ffvec_s = vec_r;
                        end else begin
                            ffv_s = ffv_r;
                        end
                    end else begin
                        err_s = err_r;
                    end
                    if (vec_r == 3'd7) begin
                        state_s = ST_DONE;
                    end else begin
                        vec_s = vec_r + 3'd1;
                    end
                end else begin
                    hold_s = hold_r + {{(HOLD_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, results and registered outputs; outputs follow the next-state values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            vec_r   <= 3'd0;
            hold_r  <= '0;
            err_r   <= '0;
            ffv_r   <= 1'b0;
            ffvec_r <= 3'd0;
            ci_o    <= 1'b0;
            xi_o    <= 1'b0;
            yi_o    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            state_r <= state_s;
            vec_r   <= vec_s;
            hold_r  <= hold_s;
            err_r   <= err_s;
            ffv_r   <= ffv_s;
            ffvec_r <= ffvec_s;
            ci_o    <= (state_s == ST_RUN) ? vec_s[2] : 1'b0;
            xi_o    <= (state_s == ST_RUN) ? vec_s[1] : 1'b0;
            yi_o    <= (state_s == ST_RUN) ? vec_s[0] : 1'b0;
            busy    <= (state_s == ST_RUN);
            done    <= (state_s == ST_DONE);
            pass    <= (state_s == ST_DONE) && (err_s == '0);
        end
    end

endmodule

// File: tb/tb_full_adder_checker.sv
// Bench for full_adder_checker: a behavioural adder with selectable faults drives two
// checkers (4-bit and 2-bit error counters); expected vectors are scoreboarded.
module tb_full_adder_checker;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    int         mode = 0;
    logic       ci, xi, yi, cout, si;
    logic       busy, done, pass, ffv;
    logic [3:0] err;
    logic [2:0] ffvec;
    logic       ci2, xi2, yi2, cout2, si2;
    logic       busy2, done2, pass2, ffv2;
    logic [1:0] err2;
    logic [2:0] ffvec2;

    int n_vec = 0;
    int n_err = 0;
    logic [2:0] vec_q[$];

    always #5 clk = ~clk;

    // mode 0 good, 1 si stuck at 0, 2 cout/si swapped, 3 si inverted; returns {cout, si}
    function automatic logic [1:0] adder_model(input int m, input logic [2:0] v);
        logic s, c;
        s = 1'b0;
        c = 1'b0;
        for (int k = 0; k < 3; k++) s = s ^ v[k];
        c = (v[2] + v[1] + v[0]) >= 2;
        case (m)
            1: return {c, 1'b0};
            2: return {s, c};
            3: return {c, ~s};
            default: return {c, s};
        endcase
    endfunction

    assign {cout, si}   = adder_model(mode, {ci, xi, yi});
    assign {cout2, si2} = adder_model(mode, {ci2, xi2, yi2});

    full_adder_checker #(.HOLD_CYCLES(HOLD), .ERR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ci_o(ci), .xi_o(xi), .yi_o(yi), .cout_i(cout), .si_i(si),
        .busy(busy), .done(done), .pass(pass), .err_count(err),
        .first_fail_valid(ffv), .first_fail_vec(ffvec)
    );

    full_adder_checker #(.HOLD_CYCLES(HOLD), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start),
        .ci_o(ci2), .xi_o(xi2), .yi_o(yi2), .cout_i(cout2), .si_i(si2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        expect_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        expect_eq({tag, "_done"}, {31'd0, done}, 32'd0);
        expect_eq({tag, "_pass"}, {31'd0, pass}, 32'd0);
        expect_eq({tag, "_err"}, {28'd0, err}, 32'd0);
        expect_eq({tag, "_ffv"}, {31'd0, ffv}, 32'd0);
        expect_eq({tag, "_ffvec"}, {29'd0, ffvec}, 32'd0);
        expect_eq({tag, "_stim"}, {29'd0, ci, xi, yi}, 32'd0);
    endtask

    // One full run in fault mode m; optionally pulses start mid-run, which must be ignored
    task automatic run_vectors(input int m, input bit poke_start);
        int cyc;
        int guard;
        int exp_err;
        int exp_err2;
        logic [2:0] exp_ff;
        bit exp_ffv;
        logic [2:0] exp_v;
        logic [2:0] v;
        logic [1:0] good;
        mode = m;
        exp_err = 0;
        exp_ff = 3'd0;
        exp_ffv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            vec_q.push_back(v);
            good = adder_model(0, v);
            if (adder_model(m, v) != good) begin
                exp_err++;
                if (!exp_ffv) begin
                    exp_ffv = 1'b1;
                    exp_ff = v;
                end
            end
        end
        exp_err2 = (exp_err > 3) ? 3 : exp_err;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        guard = 0;
        while (!done && guard < 100) begin
            if (busy) begin
                if (cyc % HOLD == 0) begin
                    exp_v = (vec_q.size() > 0) ? vec_q.pop_front() : 3'd0;
                    expect_eq("stim", {29'd0, ci, xi, yi}, {29'd0, exp_v});
                end
                cyc++;
            end
            start = poke_start && (cyc == 5);
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        expect_eq("busy_len", cyc, 8 * HOLD);
        expect_eq("busy_at_done", {31'd0, busy}, 32'd0);
        expect_eq("done", {31'd0, done}, 32'd1);
        expect_eq("pass", {31'd0, pass}, {31'd0, exp_err == 0});
        expect_eq("err_count", {28'd0, err}, exp_err);
        expect_eq("ff_valid", {31'd0, ffv}, {31'd0, exp_ffv});
        expect_eq("ff_vec", {29'd0, ffvec}, {29'd0, exp_ff});
        expect_eq("stim_idle", {29'd0, ci, xi, yi}, 32'd0);
        expect_eq("sb_empty", vec_q.size(), 32'd0);
        expect_eq("done_w2", {31'd0, done2}, 32'd1);
        expect_eq("err_w2", {30'd0, err2}, exp_err2);
        expect_eq("ff_vec_w2", {29'd0, ffvec2}, {29'd0, exp_ff});
        vec_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        run_vectors(0, 1'b0);
        run_vectors(1, 1'b0);
        run_vectors(2, 1'b0);
        run_vectors(3, 1'b0);

        // Reset at clock 10 of a run must clear everything before the next edge
        mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        expect_eq("busy_pre_rst", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_vectors(0, 1'b1);
        run_vectors(2, 1'b0);
        run_vectors(0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
